hilo_commit: RTL and testbench

- Sits directly downstream of the EX-stage ALU/divider and holds the architectural HI/LO register pair.
- Captures each HI/LO-writing result as it leaves EX: MULT/MULTU/DIV/DIVU write both halves; MTHI/MTLO write one half.
- Carries each such result through MEM and WB shadow stages and commits it at the WB edge.
- Forwards the youngest pending value back to EX so MFHI/MFLO read correct data without stalling.

---
 rtl/hilo_commit.sv | 111 +++++++++++
 tb/tb_hilo_commit.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_commit.sv
// HI/LO commit pipeline: carries HI/LO-writing results from EX through MEM and WB shadow
// stages, commits them at WB, and forwards the youngest pending value back to EX.
module hilo_commit #(
  parameter int unsigned W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ex_valid,
  input  logic           ex_hi_we,
  input  logic           ex_lo_we,
  input  logic [2*W-1:0] ex_ans,
  input  logic           en,
  input  logic           flush,
  output logic [W-1:0]   hi_o,
  output logic [W-1:0]   lo_o,
  output logic [W-1:0]   arch_hi,
  output logic [W-1:0]   arch_lo,
  output logic           pending
);

  logic         m_v_q, m_v_d, m_hwe_q, m_hwe_d, m_lwe_q, m_lwe_d;
  logic [W-1:0] m_hi_q, m_hi_d, m_lo_q, m_lo_d;
  logic         w_v_q, w_v_d, w_hwe_q, w_hwe_d, w_lwe_q, w_lwe_d;
  logic [W-1:0] w_hi_q, w_hi_d, w_lo_q, w_lo_d;
  logic [W-1:0] arch_hi_q, arch_hi_d, arch_lo_q, arch_lo_d;
  logic         commit;

  // WB is older than any faulting MEM instruction, so it retires on a flush too.
  assign commit = en | flush;

  always_comb begin
    m_v_d     = m_v_q;
    m_hwe_d   = m_hwe_q;
    m_lwe_d   = m_lwe_q;
    m_hi_d    = m_hi_q;
    m_lo_d    = m_lo_q;
    w_v_d     = w_v_q;
    w_hwe_d   = w_hwe_q;
    w_lwe_d   = w_lwe_q;
    w_hi_d    = w_hi_q;
    w_lo_d    = w_lo_q;
    arch_hi_d = arch_hi_q;
    arch_lo_d = arch_lo_q;

    if (commit && w_v_q && w_hwe_q) arch_hi_d = w_hi_q;
    if (commit && w_v_q && w_lwe_q) arch_lo_d = w_lo_q;

    if (flush) begin
      m_v_d = 1'b0;
      w_v_d = 1'b0;
    end else if (en) begin
      w_v_d   = m_v_q;
      w_hwe_d = m_hwe_q;
      w_lwe_d = m_lwe_q;
      w_hi_d  = m_hi_q;
      w_lo_d  = m_lo_q;
      // Data captured unconditionally; only the enables are qualified by ex_valid.
      m_v_d   = ex_valid & (ex_hi_we | ex_lo_we);
      m_hwe_d = ex_valid & ex_hi_we;
      m_lwe_d = ex_valid & ex_lo_we;
      m_hi_d  = ex_ans[2*W-1:W];
      m_lo_d  = ex_ans[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_v_q     <= 1'b0;
      m_hwe_q   <= 1'b0;
      m_lwe_q   <= 1'b0;
      m_hi_q    <= '0;
      m_lo_q    <= '0;
      w_v_q     <= 1'b0;
      w_hwe_q   <= 1'b0;
      w_lwe_q   <= 1'b0;
      w_hi_q    <= '0;
      w_lo_q    <= '0;
      arch_hi_q <= '0;
      arch_lo_q <= '0;
    end else begin
      m_v_q     <= m_v_d;
      m_hwe_q   <= m_hwe_d;
      m_lwe_q   <= m_lwe_d;
      m_hi_q    <= m_hi_d;
      m_lo_q    <= m_lo_d;
      w_v_q     <= w_v_d;
      w_hwe_q   <= w_hwe_d;
      w_lwe_q   <= w_lwe_d;
      w_hi_q    <= w_hi_d;
      w_lo_q    <= w_lo_d;
      arch_hi_q <= arch_hi_d;
      arch_lo_q <= arch_lo_d;
    end
  end

  // Forwarding reads registers only, so there is no combinational path from ex_*.
  always_comb begin
    if (m_v_q && m_hwe_q)      hi_o = m_hi_q;
    else if (w_v_q && w_hwe_q) hi_o = w_hi_q;
    else                       hi_o = arch_hi_q;

    if (m_v_q && m_lwe_q)      lo_o = m_lo_q;
    else if (w_v_q && w_lwe_q) lo_o = w_lo_q;
    else                       lo_o = arch_lo_q;
  end

  assign arch_hi = arch_hi_q;
  assign arch_lo = arch_lo_q;
  assign pending = m_v_q | w_v_q;

endmodule

// File: tb/tb_hilo_commit.sv
// Self-checking bench for hilo_commit: directed scenarios plus a randomized run against a
// queue-style reference model of in-flight HI/LO writes.
module tb_hilo_commit;

  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           rst, ex_valid, ex_hi_we, ex_lo_we, en, flush;
  logic [2*W-1:0] ex_ans;
  logic [W-1:0]   hi_o, lo_o, arch_hi, arch_lo;
  logic           pending;

  int n_checks = 0;
  int n_fail   = 0;

  hilo_commit #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .ex_valid (ex_valid),
    .ex_hi_we (ex_hi_we),
    .ex_lo_we (ex_lo_we),
    .ex_ans   (ex_ans),
    .en       (en),
    .flush    (flush),
    .hi_o     (hi_o),
    .lo_o     (lo_o),
    .arch_hi  (arch_hi),
    .arch_lo  (arch_lo),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  // Reference model: in-flight writes, index 0 = youngest (MEM), 1 = oldest (WB).
  typedef struct {
    bit           hwe;
    bit           lwe;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } wr_t;

  wr_t          flight[$];
  bit           slot_live[2];
  logic [W-1:0] mdl_hi = '0, mdl_lo = '0;

  function automatic void model_reset();
    flight.delete();
    slot_live[0] = 0;
    slot_live[1] = 0;
    flight.push_back('{0, 0, '0, '0});
    flight.push_back('{0, 0, '0, '0});
    mdl_hi = '0;
    mdl_lo = '0;
  endfunction

  function automatic void model_edge();
    wr_t nw;
    if (rst) begin
      model_reset();
      return;
    end
    if (en || flush) begin
      if (slot_live[1] && flight[1].hwe) mdl_hi = flight[1].hi;
      if (slot_live[1] && flight[1].lwe) mdl_lo = flight[1].lo;
    end
    if (flush) begin
      slot_live[0] = 0;
      slot_live[1] = 0;
    end else if (en) begin
      void'(flight.pop_back());
      nw.hwe = ex_valid && ex_hi_we;
      nw.lwe = ex_valid && ex_lo_we;
      nw.hi  = ex_ans[2*W-1:W];
      nw.lo  = ex_ans[W-1:0];
      flight.push_front(nw);
      slot_live[1] = slot_live[0];
      slot_live[0] = nw.hwe || nw.lwe;
    end
  endfunction

  function automatic logic [W-1:0] model_fwd(input bit hi_half);
    for (int i = 0; i < 2; i++) begin
      if (slot_live[i] && (hi_half ? flight[i].hwe : flight[i].lwe))
        return hi_half ? flight[i].hi : flight[i].lo;
    end
    return hi_half ? mdl_hi : mdl_lo;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit v, input bit h, input bit l, input logic [2*W-1:0] a,
                       input bit e, input bit f);
    ex_valid = v; ex_hi_we = h; ex_lo_we = l; ex_ans = a; en = e; flush = f; rst = 0;
  endtask

  task automatic idle();
    drive(0, 0, 0, '0, 1, 0);
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1);
    rst = 1;
    step();
    step();
    rst = 0;
    n_checks++;
    if ({hi_o, lo_o, arch_hi, arch_lo, pending} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: hi_o=%h lo_o=%h arch=%h/%h pending=%b, required all 0",
               hi_o, lo_o, arch_hi, arch_lo, pending);
    end
  endtask

  task automatic test_mult_latency();
    drive(1, 1, 1, 64'h0000_0002_0000_0003, 1, 0);
    step();
    idle();
    n_checks++;
    if (hi_o !== 32'd2 || lo_o !== 32'd3 || arch_hi !== 0 || arch_lo !== 0 || pending !== 1) begin
      n_fail++;
      $display("FAIL mult_fwd_mem: hi_o=%h lo_o=%h arch=%h/%h pending=%b, required 2/3 0/0 1",
               hi_o, lo_o, arch_hi, arch_lo, pending);
    end
    step();
    n_checks++;
    if (arch_hi !== 0 || hi_o !== 32'd2) begin
      n_fail++;
      $display("FAIL mult_in_wb: arch_hi=%h hi_o=%h, required 0 and 2", arch_hi, hi_o);
    end
    step();
    n_checks++;
    if (arch_hi !== 32'd2 || arch_lo !== 32'd3 || pending !== 0) begin
      n_fail++;
      $display("FAIL mult_commit: arch=%h/%h pending=%b, required 2/3 0", arch_hi, arch_lo,
               pending);
    end
  endtask

  task automatic test_mthi_forward();
    drive(1, 1, 1, 64'h0000_0009_0000_0005, 1, 0);
    step();
    drive(1, 1, 0, 64'hAAAA_AAAA_1234_5678, 1, 0);
    step();
    idle();
    n_checks++;
    if (hi_o !== 32'hAAAA_AAAA || lo_o !== 32'd5) begin
      n_fail++;
      $display("FAIL mthi_fwd: hi_o=%h lo_o=%h, required aaaaaaaa/5", hi_o, lo_o);
    end
    step();
    n_checks++;
    if (arch_hi !== 32'd9 || arch_lo !== 32'd5 || hi_o !== 32'hAAAA_AAAA) begin
      n_fail++;
      $display("FAIL mthi_mid: arch=%h/%h hi_o=%h, required 9/5 aaaaaaaa", arch_hi, arch_lo,
               hi_o);
    end
    step();
    n_checks++;
    if (arch_hi !== 32'hAAAA_AAAA || arch_lo !== 32'd5 || pending !== 0) begin
      n_fail++;
      $display("FAIL mthi_commit: arch=%h/%h pending=%b, required aaaaaaaa/5 0", arch_hi,
               arch_lo, pending);
    end
  endtask

  task automatic test_div_stall();
    for (int i = 0; i < 33; i++) begin
      drive(1, 1, 1, {$urandom, $urandom}, 0, 0);
      step();
    end
    n_checks++;
    if (pending !== 0 || arch_hi !== 32'hAAAA_AAAA || hi_o !== 32'hAAAA_AAAA) begin
      n_fail++;
      $display("FAIL div_stall_hold: pending=%b arch_hi=%h hi_o=%h, required 0 aaaaaaaa",
               pending, arch_hi, hi_o);
    end
    drive(1, 1, 1, 64'h0000_0001_0000_0007, 1, 0);
    step();
    idle();
    step();
    step();
    n_checks++;
    if (arch_hi !== 32'd1 || arch_lo !== 32'd7 || pending !== 0) begin
      n_fail++;
      $display("FAIL div_commit: arch=%h/%h pending=%b, required 1/7 0", arch_hi, arch_lo,
               pending);
    end
  endtask

  task automatic test_flush();
    drive(1, 1, 1, 64'h0000_0001_0000_0001, 1, 0);
    step();
    drive(1, 1, 1, 64'h0000_0002_0000_0002, 1, 0);
    step();
    drive(1, 1, 1, 64'h0000_0003_0000_0003, 1, 1);
    step();
    idle();
    n_checks++;
    if (arch_hi !== 32'd1 || arch_lo !== 32'd1 || pending !== 0 || hi_o !== 32'd1) begin
      n_fail++;
      $display("FAIL flush: arch=%h/%h pending=%b hi_o=%h, required 1/1 0 1", arch_hi, arch_lo,
               pending, hi_o);
    end
  endtask

  task automatic test_wb_stall();
    drive(1, 1, 1, 64'h0000_0055_0000_0066, 1, 0);
    step();
    idle();
    step();
    en = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (arch_hi !== 32'd1 || arch_lo !== 32'd1 || hi_o !== 32'h55 || lo_o !== 32'h66) begin
        n_fail++;
        $display("FAIL wb_stall[%0d]: arch=%h/%h fwd=%h/%h, required 1/1 55/66", i, arch_hi,
                 arch_lo, hi_o, lo_o);
      end
    end
    en = 1;
    step();
    n_checks++;
    if (arch_hi !== 32'h55 || arch_lo !== 32'h66 || pending !== 0) begin
      n_fail++;
      $display("FAIL wb_stall_commit: arch=%h/%h pending=%b, required 55/66 0", arch_hi,
               arch_lo, pending);
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 1, 1, 64'h0000_0011_0000_0022, 1, 0);
    step();
    drive(1, 1, 1, 64'h0000_0033_0000_0044, 1, 0);
    step();
    drive(1, 1, 1, 64'h0000_0077_0000_0088, 1, 1);
    rst = 1;
    step();
    rst = 0;
    n_checks++;
    if ({hi_o, lo_o, arch_hi, arch_lo, pending} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: hi_o=%h lo_o=%h arch=%h/%h pending=%b, required all 0",
               hi_o, lo_o, arch_hi, arch_lo, pending);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 1, {$urandom, $urandom}, 1, 0);
      step();
      n_checks++;
      if (hi_o !== 0 || lo_o !== 0 || pending !== 0) begin
        n_fail++;
        $display("FAIL invalid_ignored[%0d]: hi_o=%h lo_o=%h pending=%b, required 0 0 0", i,
                 hi_o, lo_o, pending);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] eh, el, ah, al;
    bit           ep;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
            {$urandom, $urandom}, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 49) == 0);
      step();
      eh = model_fwd(1);
      el = model_fwd(0);
      ah = mdl_hi;
      al = mdl_lo;
      ep = slot_live[0] || slot_live[1];
      n_checks++;
      if (hi_o !== eh || lo_o !== el || arch_hi !== ah || arch_lo !== al || pending !== ep)
      begin
        n_fail++;
        $display("FAIL random[%0d]: got fwd=%h/%h arch=%h/%h p=%b, required %h/%h %h/%h %b",
                 i, hi_o, lo_o, arch_hi, arch_lo, pending, eh, el, ah, al, ep);
      end
    end
  endtask

  initial begin
    model_reset();
    drive(0, 0, 0, '0, 0, 0);
    test_reset();
    test_mult_latency();
    test_mthi_forward();
    test_div_stall();
    test_flush();
    test_wb_stall();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
